cam_fb_writer: RTL and testbench
================================

Name: cam_fb_writer

Overview:
- Writer side of the QVGA frame buffer: captures the OV7670-style camera byte stream (RGB565, two bytes per pixel, VSYNC/HREF framing).
- Converts each pixel to RGB444 and issues one frame-buffer write per pixel at address y*H_PIX + x.
- Feeds the same 320x240 buffer the VGA output path reads. Provides capture arming, frame-boundary sync, clipping and status.

Parameters:
H_PIX, 320, pixels per stored line; x clip limit
V_LINES, 240, lines per stored frame; y clip limit
ADDR_W, 17, frame-buffer address width (must hold H_PIX*V_LINES-1)

Ports:
clk  in  1  camera pixel clock (PCLK); all logic on rising edge
reset  in  1  asynchronous, active-high reset
capture_en  in  1  level; 1 = capture frames continuously
cam_vsync  in  1  high during vertical blanking; rising edge = frame end
cam_href  in  1  high while line bytes are valid
cam_data  in  8  camera byte, sampled when cam_href=1
fb_we  out  1  frame-buffer write enable, one-cycle pulse per pixel
fb_wAddr  out  ADDR_W  frame-buffer write address
fb_wdata  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}
busy  out  1  1 while state is FRAME
frame_done  out  1  one-cycle pulse at the end of each captured frame
line_err  out  1  sticky; set when a line ends on an odd byte count; cleared on ARM entry

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous, active-high. Reset sets state=IDLE and all outputs/counters to 0.
- Input registering: cam_vsync, cam_href and cam_data are registered once.
- Edge detection: vsync rising edge (vs_rise) and href falling edge (hr_fall) are detected on the registered copies.
- State IDLE:
  - No writes.
  - capture_en=1 -> ARM.
- State ARM:
  - Clear x, y, line_base, byte phase and line_err.
  - Wait for vs_rise, so capture never starts mid-frame.
  - vs_rise -> FRAME.
  - capture_en=0 -> IDLE.
- State FRAME (busy=1):
  - Each registered-href cycle toggles the byte phase.
  - Phase 0: latch byte0.
  - Phase 1: form the pixel.
    - R = byte0[7:4].
    - G = {byte0[2:0], byte1[7]}.
    - B = byte1[4:1].
    - If x<H_PIX and y<V_LINES: next cycle fb_we=1, fb_wAddr=line_base+x, fb_wdata=pixel.
    - x increments regardless of clipping; x saturates at H_PIX.
  - Latency: fb_we rises exactly 2 cycles after the second byte is on cam_data, accounting for the input register and the output register.
  - hr_fall: if x>0, then y++ (saturating at V_LINES) and line_base += H_PIX (only while y<V_LINES). Then x=0 and phase=0.
  - hr_fall with phase=1 (dangling byte): the byte is discarded and line_err is set.
  - vs_rise: frame_done=1 for 1 cycle; x, y, line_base and phase are cleared.
    - capture_en=1: stay in FRAME.
    - capture_en=0: -> IDLE.
  - capture_en deasserted mid-frame: the current frame completes; the check happens only at vs_rise.
- Address generation: line_base + x only; no multiplier. Max address is H_PIX*V_LINES-1 (76799). Addresses never wrap.
- fb_we, fb_wAddr and fb_wdata are registered.
  - fb_we is 0 whenever no pixel completes.
  - fb_wAddr and fb_wdata hold their last values when fb_we=0.
- Simultaneous events:
  - vs_rise with href high: the frame ends, the partial pixel is dropped, and there is no y increment.
  - hr_fall on the same cycle as a completing pixel: the pixel is written first, then the line advances.
- Reset mid-frame: immediate return to IDLE with no further writes. A new capture waits for the next vs_rise.
- Lines beyond V_LINES and pixels beyond H_PIX are silently dropped and do not set line_err.

Test Plan:
- Reset, capture_en=1, drive vs pulse, then 2 lines of 4 pixels (bytes 0xF8,0x00 red) and vs pulse -> ARM then FRAME; 8 writes at addr 0..3 and 320..323, data 0xF00; frame_done pulses once after the final vs rise.
- Pixel bytes 0x07,0xE0 (pure green) then 0x00,0x1F (blue) -> fb_wdata 0x0F0 then 0x00F; fb_we high 2 cycles after each second byte.
- 330-pixel line then 245 lines -> x clipped at 319; last write addr 76799; no write for lines 240..244; line_err stays 0.
- Line with 7 bytes (3.5 pixels) -> 3 writes; line_err=1; next line starts at addr 320 with phase 0; re-arming clears line_err.
- capture_en=1 asserted mid-frame (vsync low, href active) -> no writes until after the next vs rise; the first write lands at addr 0.
- capture_en dropped mid-frame -> remaining lines still written; frame_done at vs rise; then IDLE, busy=0. Assert reset mid-line -> fb_we=0 and busy=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/cam_fb_writer.sv
// Camera-side frame buffer writer: RGB565 byte stream in, one RGB444 write per pixel.
// Pixels land at y*H_PIX + x; anything outside the stored frame is dropped.
module cam_fb_writer #(
   parameter int H_PIX   = 320,
   parameter int V_LINES = 240,
   parameter int ADDR_W  = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture_en,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_data,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_wAddr,
   output logic [11:0]       fb_wdata,
   output logic              busy,
   output logic              frame_done,
   output logic              line_err
);

   localparam int XW = $clog2(H_PIX + 1);
   localparam int YW = $clog2(V_LINES + 1);
   localparam logic [XW-1:0]     X_LIM  = XW'(H_PIX);
   localparam logic [YW-1:0]     Y_LIM  = YW'(V_LINES);
   localparam logic [ADDR_W-1:0] L_STEP = ADDR_W'(H_PIX);

   typedef enum logic [1:0] {IDLE, ARM, FRAME} state_t;

   state_t state, state_nx;

   logic              vs_q, vs_q2;
   logic              hr_q, hr_q2;
   logic [7:0]        d_q;
   logic [6:0]        b0;
   logic              vs_rise, hr_fall;
   logic              phase;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [ADDR_W-1:0] line_base;
   logic              pix_done, pix_keep;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_q  <= 1'b0;
         vs_q2 <= 1'b0;
         hr_q  <= 1'b0;
         hr_q2 <= 1'b0;
         d_q   <= '0;
      end else begin
         vs_q  <= cam_vsync;
         vs_q2 <= vs_q;
         hr_q  <= cam_href;
         hr_q2 <= hr_q;
         d_q   <= cam_data;
      end
   end

   assign vs_rise  = vs_q & ~vs_q2;
   assign hr_fall  = hr_q2 & ~hr_q;
   assign busy     = (state == FRAME);
   // a frame-ending vsync wins over a half-formed pixel
   assign pix_done = busy & ~vs_rise & hr_q & phase;
   assign pix_keep = pix_done & (x < X_LIM) & (y < Y_LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (capture_en) state_nx = ARM;
         ARM: begin
            if (!capture_en)  state_nx = IDLE;
            else if (vs_rise) state_nx = FRAME;
         end
         FRAME:   if (vs_rise && !capture_en) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_we      <= 1'b0;
         fb_wAddr   <= '0;
         fb_wdata   <= '0;
         frame_done <= 1'b0;
         line_err   <= 1'b0;
         b0         <= '0;
         phase      <= 1'b0;
         x          <= '0;
         y          <= '0;
         line_base  <= '0;
      end else begin
         fb_we      <= pix_keep;
         frame_done <= 1'b0;
         if (pix_keep) begin
            fb_wAddr <= line_base + ADDR_W'(x);
            fb_wdata <= {b0[6:3], b0[2:0], d_q[7], d_q[4:1]};
         end
         case (state)
            ARM: begin
               x         <= '0;
               y         <= '0;
               line_base <= '0;
               phase     <= 1'b0;
               line_err  <= 1'b0;
            end
            FRAME: begin
               if (vs_rise) begin
                  frame_done <= 1'b1;
                  x          <= '0;
                  y          <= '0;
                  line_base  <= '0;
                  phase      <= 1'b0;
               end else if (hr_q) begin
                  if (!phase) b0 <= {d_q[7:4], d_q[2:0]};
                  phase <= ~phase;
                  if (phase && x < X_LIM) x <= x + XW'(1);
               end else if (hr_fall) begin
                  if (phase) line_err <= 1'b1;
                  if (x != '0 && y < Y_LIM) begin
                     y         <= y + YW'(1);
                     line_base <= line_base + L_STEP;
                  end
                  x     <= '0;
                  phase <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_fb_writer.sv
// Scoreboard bench for cam_fb_writer: random camera lines against a pixel-list model.
// A negedge monitor pops expected writes whenever fb_we is seen.
module tb_cam_fb_writer;

   localparam int H  = 320;
   localparam int V  = 240;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          reset;
   logic          capture_en;
   logic          cam_vsync;
   logic          cam_href;
   logic [7:0]    cam_data;
   logic          fb_we;
   logic [AW-1:0] fb_wAddr;
   logic [11:0]   fb_wdata;
   logic          busy;
   logic          frame_done;
   logic          line_err;

   cam_fb_writer #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .capture_en(capture_en),
      .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
      .fb_we(fb_we), .fb_wAddr(fb_wAddr), .fb_wdata(fb_wdata),
      .busy(busy), .frame_done(frame_done), .line_err(line_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t exq[$];
   int  checks = 0;
   int  passed = 0;
   int  fd_seen = 0;
   int  last_addr = -1;

   // model: 0 idle, 1 waiting for frame start, 2 capturing
   int  m_mode = 0;
   int  m_y = 0;
   bit  m_err = 0;
   int  m_frames = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic int pix(input int b0, input int b1);
      int r, g, b;
      r = (b0 >> 4) & 15;
      g = ((b0 & 7) * 2) + ((b1 >> 7) & 1);
      b = (b1 >> 1) & 15;
      return r * 256 + g * 16 + b;
   endfunction

   always @(negedge clk) begin
      wr_t e;
      if (!reset) begin
         if (fb_we) begin
            last_addr = int'(fb_wAddr);
            if (exq.size() == 0) begin
               checks++;
               $display("FAIL unexpected_write: addr %0d data %03h, expected none",
                        fb_wAddr, fb_wdata);
            end else begin
               e = exq.pop_front();
               chk("wr_addr", 32'(fb_wAddr), e.addr);
               chk("wr_data", 32'(fb_wdata), e.data);
            end
         end
         if (frame_done) fd_seen++;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_cen(input bit v);
      capture_en = v;
      if (v && m_mode == 0) begin
         m_mode = 1;
         m_err  = 0;
      end
      if (!v && m_mode == 1) m_mode = 0;
      tick(2);
   endtask

   task automatic vs_pulse();
      cam_vsync = 1'b1;
      tick($urandom_range(2, 5));
      cam_vsync = 1'b0;
      tick(3);
      if (m_mode == 1) begin
         m_mode = 2;
         m_y    = 0;
      end else if (m_mode == 2) begin
         m_frames++;
         m_y = 0;
         if (!capture_en) m_mode = 0;
      end
   endtask

   // pat 0: random bytes, pat 1: pure red pixels
   task automatic send_line(input int nbytes, input int pat);
      int  b[$];
      wr_t e;
      for (int i = 0; i < nbytes; i++) begin
         if (pat == 1) b.push_back((i % 2 == 0) ? 'hF8 : 'h00);
         else          b.push_back(int'($urandom_range(0, 255)));
      end
      if (m_mode == 2) begin
         for (int p = 0; p < nbytes / 2; p++) begin
            if (p < H && m_y < V) begin
               e.addr = m_y * H + p;
               e.data = pix(b[2*p], b[2*p+1]);
               exq.push_back(e);
            end
         end
         if (nbytes >= 2 && m_y < V) m_y++;
         if (nbytes % 2 == 1) m_err = 1;
      end
      for (int i = 0; i < nbytes; i++) begin
         cam_href = 1'b1;
         cam_data = 8'(b[i]);
         tick();
      end
      cam_href = 1'b0;
      cam_data = 8'($urandom);
      tick($urandom_range(2, 4));
   endtask

   task automatic drain(input string name);
      tick(6);
      chk(name, exq.size(), 0);
   endtask

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      wr_t e;
      reset      = 1'b1;
      capture_en = 1'b0;
      cam_vsync  = 1'b0;
      cam_href   = 1'b0;
      cam_data   = 8'h00;
      tick(3);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_line_err", line_err, 0);
      chk("rst_addr", 32'(fb_wAddr), 0);
      reset = 1'b0;
      tick(2);

      // two red lines of four pixels
      set_cen(1);
      chk("arm_not_busy", busy, 0);
      vs_pulse();
      chk("frame_busy", busy, 1);
      send_line(8, 1);
      send_line(8, 1);
      vs_pulse();
      drain("red_drain");
      chk("red_frame_done", fd_seen, 1);
      chk("red_last_addr", last_addr, 323);

      // green then blue, with exact write latency
      e.addr = 0; e.data = pix('h07, 'hE0); exq.push_back(e);
      e.addr = 1; e.data = pix('h00, 'h1F); exq.push_back(e);
      m_y = 1;
      cam_href = 1'b1;
      cam_data = 8'h07;
      tick();
      cam_data = 8'hE0;
      tick();
      chk("lat_green_early", fb_we, 0);
      cam_data = 8'h00;
      tick();
      chk("lat_green", fb_we, 1);
      cam_data = 8'h1F;
      tick();
      chk("lat_blue_early", fb_we, 0);
      cam_href = 1'b0;
      tick();
      chk("lat_blue", fb_we, 1);
      tick(3);
      vs_pulse();
      drain("gb_drain");

      // clipping in both directions
      send_line(660, 0);
      for (int l = 1; l < 239; l++) send_line(2, 0);
      send_line(644, 0);
      for (int l = 0; l < 5; l++) send_line(4, 0);
      drain("clip_drain");
      chk("clip_last_addr", last_addr, 76799);
      chk("clip_line_err", line_err, 0);
      vs_pulse();

      // dangling byte, then re-arm
      send_line(7, 0);
      chk("odd_line_err", line_err, 1);
      send_line(8, 0);
      drain("odd_drain");
      chk("odd_next_addr", last_addr, 323);
      set_cen(0);
      vs_pulse();
      chk("odd_idle", busy, 0);
      chk("odd_sticky", line_err, 1);
      set_cen(1);
      chk("rearm_clear", line_err, m_err);

      // enable arrives mid-frame
      set_cen(0);
      send_line(8, 0);
      set_cen(1);
      send_line(8, 0);
      send_line(8, 0);
      drain("mid_none");
      chk("mid_no_writes", last_addr, 323);
      vs_pulse();
      send_line(6, 0);
      drain("mid_drain");
      chk("mid_first_addr", last_addr, 2);

      // enable dropped mid-frame: frame still completes
      set_cen(0);
      send_line(8, 0);
      drain("drop_drain");
      chk("drop_addr", last_addr, 323);
      chk("drop_busy_mid", busy, 1);
      vs_pulse();
      chk("drop_idle", busy, 0);
      chk("drop_frames", fd_seen, m_frames);

      // random frame
      set_cen(1);
      vs_pulse();
      for (int l = 0; l < 30; l++) begin
         int n;
         n = int'($urandom_range(0, 40));
         if ($urandom_range(0, 7) != 0) n = n & ~1;
         send_line(n, 0);
      end
      drain("rand_drain");
      chk("rand_line_err", line_err, m_err);
      vs_pulse();
      chk("rand_frames", fd_seen, m_frames);

      // asynchronous reset in the middle of a line
      cam_href = 1'b1;
      cam_data = 8'($urandom);
      tick();
      cam_data = 8'($urandom);
      tick();
      cam_data = 8'($urandom);
      tick();
      chk("pre_reset_we", fb_we, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_we", fb_we, 0);
      chk("async_rst_busy", busy, 0);
      capture_en = 1'b0;
      cam_href   = 1'b0;
      tick(2);
      reset  = 1'b0;
      m_mode = 0;
      m_y    = 0;
      exq.delete();
      tick(2);

      // after reset capture waits for a frame start
      set_cen(1);
      send_line(4, 0);
      drain("post_rst_none");
      vs_pulse();
      send_line(4, 1);
      drain("post_rst_drain");
      chk("post_rst_addr", last_addr, 1);
      chk("final_frames", fd_seen, m_frames);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
